// File: rtl/instruction_fetch_queue.sv
// Instruction fetch queue: fetches 32-bit words from RAM over the MFC
// handshake, buffers them with their addresses and hands one word per
// IR_Enable pulse to the IR stage. A redirect flushes and restarts fetch.
//
// Handshakes:
//   RAM side: mem_enable is the request valid and MFC is the completion.
//     mem_enable and mem_addr hold steady from the issue edge until the edge
//     that samples MFC=1. mem_data_in is captured on that edge.
//   IR side: a word moves on an edge where the queue is non-empty, ir_ready=1
//     and redirect=0. IR_Enable is the one-cycle valid for IR_In/ir_pc.
module instruction_fetch_queue #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          QDEPTH     = 2,
  parameter logic [5:0]  RD_WORD_OP = 6'b000000
) (
  input  logic        Clk,
  input  logic        RESET,
  input  logic        ir_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  input  logic [31:0] mem_data_in,
  input  logic        MFC,
  output logic [31:0] mem_addr,
  output logic        mem_enable,
  output logic [5:0]  RAM_OpCode,
  output logic [31:0] IR_In,
  output logic        IR_Enable,
  output logic [31:0] ir_pc,
  output logic        align_err,
  output logic [0:0]  dbg_state
);

  localparam int PW = (QDEPTH > 2) ? 2 : 1;
  localparam logic [PW:0]   DEPTH   = (PW+1)'(QDEPTH);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]    state;
  logic [31:0]   fpc;
  logic          discard;
  logic [PW:0]   count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [31:0]   q_word [QDEPTH];
  logic [31:0]   q_addr [QDEPTH];

  logic          do_push;
  logic          do_pop;
  logic [31:0]   redirect_pc;

  assign RAM_OpCode = RD_WORD_OP;
  assign dbg_state  = state;

  // Queue movement and the word-aligned redirect target.
  always_comb begin
    redirect_pc = {redirect_addr[31:2], 2'b00};
    do_push     = (state == WAIT) && MFC && !discard && !redirect;
    do_pop      = !redirect && (count != '0) && ir_ready;
  end

  // Fetch FSM, fetch address and the discard flag for orphaned requests.
  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      fpc        <= RESET_PC;
      discard    <= 1'b0;
      mem_enable <= 1'b0;
      mem_addr   <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) begin
            fpc <= redirect_pc;
          end else if (count < DEPTH) begin
            state      <= WAIT;
            mem_enable <= 1'b1;
            mem_addr   <= fpc;
          end
        end
        WAIT: begin
          if (MFC) begin
            // The returned word is kept only if no redirect happened since issue.
            if (redirect)     fpc <= redirect_pc;
            else if (!discard) fpc <= fpc + 32'd4;
            discard    <= 1'b0;
            mem_enable <= 1'b0;
            state      <= IDLE;
          end else if (redirect) begin
            // Request stays on the bus until MFC; its data will be dropped.
            fpc     <= redirect_pc;
            discard <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Queue pointers and occupancy; redirect empties the queue.
  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (redirect) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Queue storage; contents are only meaningful below count.
  always_ff @(posedge Clk) begin
    if (do_push) begin
      q_word[wr_ptr] <= mem_data_in;
      q_addr[wr_ptr] <= mem_addr;
    end
  end

  // IR delivery: one-cycle strobe, word and address hold between pulses.
  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      IR_Enable <= 1'b0;
      IR_In     <= 32'h0;
      ir_pc     <= 32'h0;
    end else begin
      IR_Enable <= do_pop;
      if (do_pop) begin
        IR_In <= q_word[rd_ptr];
        ir_pc <= q_addr[rd_ptr];
      end
    end
  end

  // Misaligned redirect target flag, one cycle per redirect.
  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) align_err <= 1'b0;
    else        align_err <= redirect && (redirect_addr[1:0] != 2'b00);
  end

endmodule

// File: doc/instruction_fetch_queue.md
Name: instruction_fetch_queue

Overview:
Upstream feeder for the IR stage. It fetches 32-bit instruction words from RAM through the MFC handshake and buffers them in a small queue. It then delivers one word per IR_Enable pulse on IR_In, replacing the hand-driven IR_In/IR_Enable stimulus. On a control-unit redirect (branch, trap) it flushes and restarts fetch at a new address.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded at reset; must be word aligned.
QDEPTH, 2, instruction queue entries; legal values 2 or 4.
RD_WORD_OP, 6'b000000, RAM_OpCode value driven for a word read.

Ports:
Clk  input  1  system clock; all state updates on rising edge.
RESET  input  1  asynchronous reset, active-low.
ir_ready  input  1  control unit can accept the next instruction this cycle.
redirect  input  1  flush the queue and restart fetch.
redirect_addr  input  32  new fetch address, valid with redirect.
mem_data_in  input  32  RAM read data, valid when MFC=1.
MFC  input  1  memory function complete.
mem_addr  output  32  RAM address.
mem_enable  output  1  RAM request strobe.
RAM_OpCode  output  6  RAM operation, always RD_WORD_OP.
IR_In  output  32  instruction word to IR.
IR_Enable  output  1  one-cycle IR load strobe.
ir_pc  output  32  address of the word on IR_In.
align_err  output  1  one-cycle pulse when redirect_addr[1:0] != 0.

Behaviour:
- Reset (RESET=0, asynchronous):
  - fpc=RESET_PC, queue empty, FSM=IDLE, discard=0.
  - IR_In=0, IR_Enable=0, ir_pc=0, mem_enable=0, mem_addr=RESET_PC, align_err=0.
- FSM states IDLE, WAIT.
  - IDLE -> WAIT when (queue count + 0 outstanding) < QDEPTH and redirect=0. Same cycle's registered outputs: mem_enable=1, mem_addr=fpc.
  - WAIT: hold mem_enable and mem_addr stable until MFC sampled 1.
  - On the MFC=1 edge: capture mem_data_in with tag fpc unless discard=1; fpc<=fpc+4; mem_enable<=0; go to IDLE.
  - Maximum one outstanding request. Minimum 1 idle cycle between requests (mem_enable deasserts for at least one cycle).
- fpc wraps 32'hFFFF_FFFC -> 32'h0000_0000; no error raised.
- Queue:
  - FIFO of {word, address}; count 0..QDEPTH.
  - Never pushed when full; the request logic guarantees space.
- Delivery: when count>0 and ir_ready=1, next edge sets IR_Enable=1, IR_In=head word, ir_pc=head address, and pops.
  - IR_Enable is low in every other cycle.
  - IR_In and ir_pc hold their last value when IR_Enable=0.
- Latency: capture edge -> IR_Enable at earliest next edge (no bypass). RESET release -> first IR_Enable at cycle 3 with a 1-cycle-MFC memory.
- Push and pop in the same cycle: count unchanged, order preserved.
- Redirect (highest priority):
  - Queue cleared and fpc<=redirect_addr & ~32'h3. align_err=1 for one cycle if the low bits were nonzero.
  - Any pop that cycle is suppressed: IR_Enable=0.
  - If in WAIT, the request is not aborted: mem_enable stays until MFC, discard<=1, and the returned word is dropped, with fpc set to the redirect target, not incremented.
  - redirect and MFC in the same cycle: returned word dropped; fpc=redirect target.
  - Back-to-back redirects: last one wins.
- RESET asserted mid-WAIT: mem_enable drops immediately. The memory must tolerate an abandoned request.

Test Plan:
- Reset release, MFC returns 1 cycle after mem_enable with words 32'h8200_2003, 32'h8400_2006, ir_ready=1 -> IR_Enable pulses carry those words with ir_pc=0 then 4. First pulse 3 cycles after reset.
- ir_ready=0 for 10 cycles, QDEPTH=2 -> exactly 2 fetches (addr 0, 4), then mem_enable stays 0. Raising ir_ready delivers both in order, then fetch resumes at addr 8.
- Redirect to 32'h0000_0040 while in WAIT for addr 8 -> word for addr 8 (32'h0500_00FF) never reaches IR_Enable. Next fetch address 0x40; ir_pc of next delivery = 0x40.
- Redirect with redirect_addr=32'h0000_0042 coincident with MFC -> align_err one-cycle pulse, returned word dropped, next mem_addr=0x40.
- Set fpc to 32'hFFFF_FFFC via redirect, 2 fetches -> mem_addr sequence FFFF_FFFC, 0000_0000; ir_pc matches each.
- Assert RESET low during WAIT with a queue of 1 -> same cycle mem_enable=0, IR_Enable=0. After release, refetch from RESET_PC with no stale word delivered.
